// File: rtl/time_keeper.sv
// 24-hour BCD clock with a one-second prescaler and a mode/inc
// button pair for setting hours and minutes.

module time_keeper_debounce #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            // Any sample matching the accepted level restarts the count.
            if (sync2 != level) begin
                if (cnt == CNT_MAX) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

module time_keeper #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [1:0] hr_tens,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_t;

    mode_t         state;
    logic [PW-1:0] presc;
    logic          mode_ev;
    logic          inc_ev;

    time_keeper_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_db_mode (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_mode),
        .press(mode_ev)
    );

    time_keeper_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_db_inc (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_inc),
        .press(inc_ev)
    );

    logic       sec_wrap;
    logic       min_wrap;
    logic       hr_wrap;
    logic [3:0] sec_ones_n;
    logic [2:0] sec_tens_n;
    logic [3:0] min_ones_n;
    logic [2:0] min_tens_n;
    logic [3:0] hr_ones_n;
    logic [1:0] hr_tens_n;

    assign sec_wrap = (sec_ones == 4'd9) && (sec_tens == 3'd5);
    assign min_wrap = (min_ones == 4'd9) && (min_tens == 3'd5);
    assign hr_wrap  = (hr_ones == 4'd3) && (hr_tens == 2'd2);

    // Each *_n is the digit pair's own +1 value, wrapping within its range.
    always_comb begin
        sec_ones_n = sec_ones + 4'd1;
        sec_tens_n = sec_tens;
        if (sec_ones == 4'd9) begin
            sec_ones_n = 4'd0;
            sec_tens_n = (sec_tens == 3'd5) ? 3'd0 : sec_tens + 3'd1;
        end

        min_ones_n = min_ones + 4'd1;
        min_tens_n = min_tens;
        if (min_ones == 4'd9) begin
            min_ones_n = 4'd0;
            min_tens_n = (min_tens == 3'd5) ? 3'd0 : min_tens + 3'd1;
        end

        hr_ones_n = hr_ones + 4'd1;
        hr_tens_n = hr_tens;
        if (hr_wrap) begin
            hr_ones_n = 4'd0;
            hr_tens_n = 2'd0;
        end else if (hr_ones == 4'd9) begin
            hr_ones_n = 4'd0;
            hr_tens_n = hr_tens + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            presc    <= '0;
            tick     <= 1'b0;
            sec_ones <= 4'd0;
            sec_tens <= 3'd0;
            min_ones <= 4'd0;
            min_tens <= 3'd0;
            hr_ones  <= 4'd0;
            hr_tens  <= 2'd0;
        end else begin
            tick <= 1'b0;
            case (state)
                RUN: begin
                    if (mode_ev) begin
                        state    <= SET_HR;
                        presc    <= '0;
                        sec_ones <= 4'd0;
                        sec_tens <= 3'd0;
                    end else if (presc == PRESC_MAX) begin
                        presc    <= '0;
                        tick     <= 1'b1;
                        sec_ones <= sec_ones_n;
                        sec_tens <= sec_tens_n;
                        if (sec_wrap) begin
                            min_ones <= min_ones_n;
                            min_tens <= min_tens_n;
                        end
                        if (sec_wrap && min_wrap) begin
                            hr_ones <= hr_ones_n;
                            hr_tens <= hr_tens_n;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                SET_HR: begin
                    presc <= '0;
                    if (mode_ev) begin
                        state <= SET_MIN;
                    end else if (inc_ev) begin
                        hr_ones <= hr_ones_n;
                        hr_tens <= hr_tens_n;
                    end
                end
                SET_MIN: begin
                    presc <= '0;
                    if (mode_ev) begin
                        state <= RUN;
                    end else if (inc_ev) begin
                        min_ones <= min_ones_n;
                        min_tens <= min_tens_n;
                    end
                end
                default: begin
                    state <= RUN;
                    presc <= '0;
                end
            endcase
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus random button traffic,
// every cycle compared against a time-of-day reference model.

module tb_time_keeper;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic [3:0] hr_ones;
    logic [1:0] hr_tens;
    logic [1:0] mode;
    logic       tick;
    logic [19:0] digits_obs;

    time_keeper #(
        .CLK_HZ(CLK_HZ),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .min_ones(min_ones),
        .min_tens(min_tens),
        .hr_ones (hr_ones),
        .hr_tens (hr_tens),
        .mode    (mode),
        .tick    (tick)
    );

    assign digits_obs = {hr_tens, hr_ones, min_tens, min_ones,
                         sec_tens, sec_ones};

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: seconds since midnight, mode number, prescaler phase.
    int tod = 0;
    int m_mode = 0;
    int m_presc = 0;
    bit m_tick = 0;
    bit r1[2];
    bit r2[2];
    bit win[2][DEB];
    bit deb[2];
    bit pend[2];

    function automatic logic [19:0] pack(int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
                3'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(string tag, logic [19:0] obs, logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit raw[2];
        bit ev[2];
        bit s, all_diff, old;
        int mi;
        raw[0] = btn_mode;
        raw[1] = btn_inc;
        if (!reset) begin
            tod = 0;
            m_mode = 0;
            m_presc = 0;
            m_tick = 0;
            for (int b = 0; b < 2; b++) begin
                r1[b] = 0;
                r2[b] = 0;
                deb[b] = 0;
                pend[b] = 0;
                for (int k = 0; k < DEB; k++) win[b][k] = 0;
            end
        end else begin
            ev = pend;
            for (int b = 0; b < 2; b++) begin
                s = r2[b];
                r2[b] = r1[b];
                r1[b] = raw[b];
                for (int k = 0; k < DEB - 1; k++) win[b][k] = win[b][k+1];
                win[b][DEB-1] = s;
                all_diff = 1;
                for (int k = 0; k < DEB; k++)
                    if (win[b][k] == deb[b]) all_diff = 0;
                old = deb[b];
                if (all_diff) deb[b] = ~deb[b];
                pend[b] = deb[b] & ~old;
            end
            m_tick = 0;
            if (m_mode == 0) begin
                if (ev[0]) begin
                    m_mode = 1;
                    tod = tod - tod % 60;
                    m_presc = 0;
                end else if (m_presc == CLK_HZ - 1) begin
                    m_presc = 0;
                    m_tick = 1;
                    tod = (tod + 1) % 86400;
                end else begin
                    m_presc++;
                end
            end else if (m_mode == 1) begin
                m_presc = 0;
                if (ev[0]) m_mode = 2;
                else if (ev[1]) tod = (tod + 3600) % 86400;
            end else begin
                m_presc = 0;
                if (ev[0]) begin
                    m_mode = 0;
                end else if (ev[1]) begin
                    mi = (tod / 60) % 60;
                    tod = tod + (((mi + 1) % 60) - mi) * 60;
                end
            end
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("digits", digits_obs, pack(tod));
            chk("mode", {18'b0, mode}, 20'(m_mode));
            chk("tick", {19'b0, tick}, {19'b0, m_tick});
        end
    endtask

    task automatic press(bit m, bit i, int hold);
        btn_mode = m;
        btn_inc = i;
        cyc(hold);
        btn_mode = 0;
        btn_inc = 0;
        cyc(8);
    endtask

    task automatic do_reset();
        reset = 0;
        cyc(2);
        reset = 1;
    endtask

    initial begin
        int n;
        logic [19:0] e;

        // Reset state
        reset = 0;
        cyc(3);
        chk("rst_digits", digits_obs, 20'h0);
        chk("rst_mode", {18'b0, mode}, 20'h0);
        chk("rst_tick", {19'b0, tick}, 20'h0);

        // First ticks after reset release
        reset = 1;
        cyc(9);
        chk("no_tick_9", {19'b0, tick}, 20'h0);
        cyc(1);
        chk("tick_10", {19'b0, tick}, 20'h1);
        chk("sec_1", digits_obs, 20'h00001);
        cyc(10);
        chk("tick_20", {19'b0, tick}, 20'h1);
        chk("sec_2", digits_obs, 20'h00002);

        // Three mode presses at 00:00:37
        cyc(350);
        chk("at_37", digits_obs, pack(37));
        press(1, 0, 8);
        chk("set_hr_mode", {18'b0, mode}, 20'd1);
        chk("set_hr_sec0", digits_obs, 20'h0);
        press(1, 0, 8);
        chk("set_min_mode", {18'b0, mode}, 20'd2);
        btn_mode = 1;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (mode != 2'd0 && n < 20);
        chk("back_to_run", {18'b0, mode}, 20'd0);
        btn_mode = 0;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (tick !== 1'b1 && n < 30);
        chk("first_tick_gap", 20'(n), 20'd10);
        chk("sec_after_run", digits_obs, 20'h00001);

        // Glitch rejection on btn_inc, then a clean hold
        do_reset();
        press(1, 0, 8);
        btn_inc = 1;
        cyc(3);
        btn_inc = 0;
        cyc(10);
        chk("glitch_ignored", digits_obs, 20'h0);
        press(0, 1, 10);
        chk("hold_inc_once", digits_obs, pack(3600));

        // Set 23:59 and roll over midnight
        repeat (22) press(0, 1, 6);
        press(1, 0, 6);
        repeat (59) press(0, 1, 6);
        chk("set_2359", digits_obs, pack(23 * 3600 + 59 * 60));
        press(1, 0, 6);
        n = 0;
        while (digits_obs !== pack(86399) && n < 700) begin
            cyc(1);
            n++;
        end
        chk("reach_235959", digits_obs, pack(86399));
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (tick !== 1'b1 && n < 15);
        chk("midnight_tick", {19'b0, tick}, 20'h1);
        chk("midnight_digits", digits_obs, 20'h0);

        // Minute wrap without hour carry; simultaneous presses
        do_reset();
        press(1, 0, 6);
        repeat (5) press(0, 1, 6);
        press(1, 0, 6);
        repeat (59) press(0, 1, 6);
        chk("min59_hr05", digits_obs, pack(5 * 3600 + 59 * 60));
        press(0, 1, 6);
        chk("min_wrap", digits_obs, pack(5 * 3600));
        press(1, 1, 6);
        e = pack(5 * 3600);
        chk("both_mode", {18'b0, mode}, 20'd0);
        chk("both_min", {7'b0, digits_obs[19:7]}, {7'b0, e[19:7]});

        // Reset in SET_HR
        do_reset();
        press(1, 0, 6);
        repeat (14) press(0, 1, 6);
        chk("hr14", digits_obs, pack(14 * 3600));
        reset = 0;
        cyc(1);
        reset = 1;
        chk("mid_rst_mode", {18'b0, mode}, 20'd0);
        chk("mid_rst_digits", digits_obs, 20'h0);
        chk("mid_rst_tick", {19'b0, tick}, 20'h0);

        // Random button traffic
        repeat (200) begin
            n = int'($urandom_range(0, 39));
            if (n == 0) begin
                reset = 0;
                cyc(1);
                reset = 1;
            end else if (n < 12) begin
                btn_mode = 1;
                cyc(int'($urandom_range(1, 9)));
                btn_mode = 0;
            end else if (n < 30) begin
                btn_inc = 1;
                if (n == 29) btn_mode = 1;
                cyc(int'($urandom_range(1, 9)));
                btn_inc = 0;
                btn_mode = 0;
            end
            cyc(int'($urandom_range(1, 30)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
